// File: rtl/vc_router_pkg.sv
// Shared definitions for the virtual channel router: flit geometry, idle flit
// and flit type encodings.
package vc_router_pkg;

    localparam int FLIT_W = 32;
    localparam logic [FLIT_W-1:0] IDLE_FLIT = 32'h6000_0000;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;

    typedef enum logic [1:0] {
        TYPE_BODY = 2'b00,
        TYPE_IDLE = 2'b01,
        TYPE_HEAD = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping modulo N, wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    always_comb begin
        int              idx;
        logic [IDX_W-1:0] idx_v;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(i_ptr) + k) % N;
            idx_v = IDX_W'(idx);
            if (!o_gnt_vld && i_req[idx_v]) begin
                o_gnt_vld    = 1'b1;
                o_gnt[idx_v] = 1'b1;
                o_gnt_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/vc_link_arbiter.sv
// Output-port link scheduler: round-robin shares one registered 32-bit link
// between NUM_VC credit-gated virtual channels.
module vc_link_arbiter
    import vc_router_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int VC_W      = 2,
    parameter int BUF_DEPTH = 4,
    parameter int CRD_W     = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NUM_VC-1:0]        vc_req,
    input  logic [FLIT_W*NUM_VC-1:0] vc_flit,
    output logic [NUM_VC-1:0]        vc_gnt,
    input  logic [NUM_VC-1:0]        credit_in,
    output logic [FLIT_W-1:0]        link_flit,
    output logic [VC_W-1:0]          link_vc,
    output logic                     link_valid,
    output logic [NUM_VC-1:0]        credit_avail,
    output logic                     credit_err
);

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);
    localparam logic [VC_W-1:0]  LAST_VC = VC_W'(NUM_VC - 1);

    logic [VC_W-1:0]   r_ptr;
    logic [CRD_W-1:0]  r_credit [NUM_VC];
    logic              r_credit_err;
    logic [FLIT_W-1:0] r_link_flit;
    logic [VC_W-1:0]   r_link_vc;
    logic              r_link_valid;

    logic [NUM_VC-1:0] w_elig;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_arb_gnt;
    logic [NUM_VC-1:0] w_gnt;
    logic [VC_W-1:0]   w_gnt_idx;
    logic              w_arb_vld;
    logic              w_gnt_vld;
    logic [FLIT_W-1:0] w_sel_flit;
    logic [VC_W-1:0]   w_ptr_next;
    logic              w_overflow;

    always_comb begin
        w_elig = '0;
        w_full = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_elig[i] = vc_req[i] & (r_credit[i] != '0);
            w_full[i] = (r_credit[i] == CRD_MAX);
        end
    end

    rr_arbiter #(
        .N     (NUM_VC),
        .IDX_W (VC_W)
    ) u_rr_arbiter (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_arb_vld)
    );

    // Handshake: a VC presents vc_req with a stable vc_flit; the flit is
    // consumed in the cycle its vc_gnt bit is high. No grant is issued while
    // clr is asserted, so a reset never silently swallows a flit.
    assign w_gnt      = w_arb_gnt & {NUM_VC{clr}};
    assign w_gnt_vld  = w_arb_vld & clr;
    assign w_sel_flit = vc_flit[FLIT_W*w_gnt_idx +: FLIT_W];
    assign w_ptr_next = (w_gnt_idx == LAST_VC) ? '0 : w_gnt_idx + 1'b1;
    assign w_overflow = |(credit_in & ~w_gnt & w_full);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr        <= '0;
            r_credit_err <= 1'b0;
            r_link_flit  <= IDLE_FLIT;
            r_link_vc    <= '0;
            r_link_valid <= 1'b0;
        end else begin
            if (w_gnt_vld) begin
                r_ptr        <= w_ptr_next;
                r_link_flit  <= w_sel_flit;
                r_link_vc    <= w_gnt_idx;
                r_link_valid <= 1'b1;
            end else begin
                r_link_flit  <= IDLE_FLIT;
                r_link_vc    <= '0;
                r_link_valid <= 1'b0;
            end
            if (w_overflow) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    // A returned credit into a full counter saturates; a grant plus a return
    // in the same cycle cancel out.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_credit[i] <= CRD_MAX;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (credit_in[i] && !w_gnt[i]) begin
                    if (!w_full[i]) begin
                        r_credit[i] <= r_credit[i] + 1'b1;
                    end
                end else if (w_gnt[i] && !credit_in[i]) begin
                    r_credit[i] <= r_credit[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        credit_avail = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            credit_avail[i] = (r_credit[i] != '0);
        end
    end

    assign vc_gnt     = w_gnt;
    assign link_flit  = r_link_flit;
    assign link_vc    = r_link_vc;
    assign link_valid = r_link_valid;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Self-checking bench for vc_link_arbiter: queue/array reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_vc_link_arbiter;

    localparam int NUM_VC    = 4;
    localparam int VC_W      = 2;
    localparam int BUF_DEPTH = 4;
    localparam int CRD_W     = 4;
    localparam int W         = VC_W + 32;
    localparam logic [31:0] IDLE = 32'h6000_0000;

    logic                   clk;
    logic                   clr;
    logic [NUM_VC-1:0]      vc_req;
    logic [32*NUM_VC-1:0]   vc_flit;
    logic [NUM_VC-1:0]      vc_gnt;
    logic [NUM_VC-1:0]      credit_in;
    logic [31:0]            link_flit;
    logic [VC_W-1:0]        link_vc;
    logic                   link_valid;
    logic [NUM_VC-1:0]      credit_avail;
    logic                   credit_err;

    vc_link_arbiter #(
        .NUM_VC    (NUM_VC),
        .VC_W      (VC_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CRD_W     (CRD_W)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .vc_req       (vc_req),
        .vc_flit      (vc_flit),
        .vc_gnt       (vc_gnt),
        .credit_in    (credit_in),
        .link_flit    (link_flit),
        .link_vc      (link_vc),
        .link_valid   (link_valid),
        .credit_avail (credit_avail),
        .credit_err   (credit_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int             m_credit [NUM_VC];
    int             m_ptr;
    bit             m_err;
    logic [W-1:0]   exp_q[$];

    always @(negedge clk) begin
        logic [NUM_VC-1:0] e_avail;
        logic [NUM_VC-1:0] e_gnt;
        logic [W-1:0]      e;
        int g;
        int j;
        if (!clr) begin
            for (int i = 0; i < NUM_VC; i++) m_credit[i] = BUF_DEPTH;
            m_ptr = 0;
            m_err = 0;
            exp_q.delete();
            check("rst_link_flit", 64'(link_flit), 64'(IDLE));
            check("rst_link_valid", 64'(link_valid), 64'd0);
            check("rst_link_vc", 64'(link_vc), 64'd0);
            check("rst_credit_avail", 64'(credit_avail), 64'hF);
            check("rst_credit_err", 64'(credit_err), 64'd0);
            check("rst_vc_gnt", 64'(vc_gnt), 64'd0);
        end else begin
            e_avail = '0;
            for (int i = 0; i < NUM_VC; i++) e_avail[i] = (m_credit[i] != 0);
            check("credit_avail", 64'(credit_avail), 64'(e_avail));
            check("credit_err", 64'(credit_err), 64'(m_err));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("link_valid", 64'(link_valid), 64'd1);
                check("link_vc", 64'(link_vc), 64'(e[W-1:32]));
                check("link_flit", 64'(link_flit), 64'(e[31:0]));
            end else begin
                check("link_valid_idle", 64'(link_valid), 64'd0);
                check("link_vc_idle", 64'(link_vc), 64'd0);
                check("link_flit_idle", 64'(link_flit), 64'(IDLE));
            end
            g = -1;
            for (int k = 0; k < NUM_VC; k++) begin
                j = (m_ptr + k) % NUM_VC;
                if (g < 0 && vc_req[j] && m_credit[j] > 0) g = j;
            end
            e_gnt = '0;
            if (g >= 0) e_gnt[g] = 1'b1;
            check("vc_gnt", 64'(vc_gnt), 64'(e_gnt));
            if (g >= 0) begin
                exp_q.push_back({VC_W'(g), vc_flit[32*g +: 32]});
                m_ptr = (g + 1) % NUM_VC;
            end
            for (int i = 0; i < NUM_VC; i++) begin
                if (credit_in[i] && g != i) begin
                    if (m_credit[i] == BUF_DEPTH) m_err = 1;
                    else m_credit[i]++;
                end else if (!credit_in[i] && g == i) begin
                    m_credit[i]--;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        step(1);
        clr       = 1'b0;
        vc_req    = '0;
        credit_in = '0;
        step(2);
        clr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clr       = 1'b1;
        vc_req    = '0;
        credit_in = '0;
        for (int i = 0; i < NUM_VC; i++) vc_flit[32*i +: 32] = 32'h8000_0000 | i;
        #1 clr = 1'b0;
        step(2);
        clr = 1'b1;

        // idle after reset
        step(5);
        settle();
        check("idle_link_flit", 64'(link_flit), 64'h6000_0000);
        check("idle_link_valid", 64'(link_valid), 64'd0);
        check("idle_credit_avail", 64'(credit_avail), 64'hF);
        check("idle_credit_err", 64'(credit_err), 64'd0);

        // all VCs requesting with credits returned every cycle
        vc_req    = 4'b1111;
        credit_in = 4'b1111;
        settle();
        check("rr_first_gnt", 64'(vc_gnt), 64'b0001);
        step(1);
        settle();
        check("rr_link_vc0", 64'(link_vc), 64'd0);
        check("rr_link_flit0", 64'(link_flit), 64'h8000_0000);
        check("rr_second_gnt", 64'(vc_gnt), 64'b0010);
        step(3);
        settle();
        check("rr_link_vc3", 64'(link_vc), 64'd3);
        check("rr_link_flit3", 64'(link_flit), 64'h8000_0003);
        check("rr_wrap_gnt", 64'(vc_gnt), 64'b0001);
        step(4);
        do_reset();

        // VC1 alone drains its credits, then one credit buys one grant
        vc_req = 4'b0010;
        settle();
        check("vc1_gnt0", 64'(vc_gnt), 64'b0010);
        step(4);
        settle();
        check("vc1_starved_gnt", 64'(vc_gnt), 64'd0);
        check("vc1_starved_avail", 64'(credit_avail), 64'b1101);
        step(1);
        settle();
        check("vc1_link_idle_valid", 64'(link_valid), 64'd0);
        check("vc1_link_idle_flit", 64'(link_flit), 64'h6000_0000);
        credit_in = 4'b0010;
        settle();
        check("vc1_ret_cycle_gnt", 64'(vc_gnt), 64'd0);
        step(1);
        credit_in = '0;
        settle();
        check("vc1_one_more_gnt", 64'(vc_gnt), 64'b0010);
        step(1);
        settle();
        check("vc1_after_gnt", 64'(vc_gnt), 64'd0);
        check("vc1_after_link_vc", 64'(link_vc), 64'd1);
        check("vc1_after_avail", 64'(credit_avail), 64'b1101);
        do_reset();

        // VC2 at one credit: grant and return together keep it at one
        vc_flit[64 +: 32] = 32'h0ABC_DEF2;
        vc_req = 4'b0100;
        step(3);
        credit_in = 4'b0100;
        settle();
        check("vc2_last_crd_gnt", 64'(vc_gnt), 64'b0100);
        step(1);
        credit_in = '0;
        settle();
        check("vc2_regrant", 64'(vc_gnt), 64'b0100);
        check("vc2_link_flit", 64'(link_flit), 64'h0ABC_DEF2);
        step(1);
        settle();
        check("vc2_drained_gnt", 64'(vc_gnt), 64'd0);
        check("vc2_drained_avail", 64'(credit_avail), 64'b1011);
        vc_flit[64 +: 32] = 32'h8000_0002;
        do_reset();

        // credit overflow on VC3
        credit_in = 4'b1000;
        step(1);
        credit_in = '0;
        settle();
        check("ovf_err_set", 64'(credit_err), 64'd1);
        check("ovf_avail", 64'(credit_avail), 64'hF);
        step(3);
        settle();
        check("ovf_err_sticky", 64'(credit_err), 64'd1);
        vc_req = 4'b1000;
        step(4);
        settle();
        check("ovf_vc3_four_only", 64'(vc_gnt), 64'd0);
        check("ovf_vc3_avail", 64'(credit_avail), 64'b0111);
        do_reset();
        settle();
        check("ovf_err_cleared", 64'(credit_err), 64'd0);

        // reset asserted mid-stream
        vc_req = 4'b1111;
        step(3);
        settle();
        check("mid_gnt_before", 64'(vc_gnt), 64'b1000);
        clr = 1'b0;
        settle();
        check("mid_rst_flit", 64'(link_flit), 64'h6000_0000);
        check("mid_rst_valid", 64'(link_valid), 64'd0);
        check("mid_rst_gnt", 64'(vc_gnt), 64'd0);
        step(2);
        clr = 1'b1;
        settle();
        check("mid_first_gnt_vc0", 64'(vc_gnt), 64'b0001);
        step(3);
        vc_req = '0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
